// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream valid-ready stream bundle for one elastic pipeline stage.
// The stage itself uses the slave modport; the producer/consumer side uses master.
interface pipe_stage_skid_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NCH   = 6,
  parameter int unsigned REG_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [NCH*DW-1:0]   in_data;
  logic [REG_W-1:0]    in_reg;
  logic                out_valid;
  logic                out_ready;
  logic [NCH*DW-1:0]   out_data;
  logic [REG_W-1:0]    out_reg;

  modport master (
    output in_valid, in_data, in_reg, out_ready,
    input  in_ready, out_valid, out_data, out_reg
  );

  modport slave (
    input  in_valid, in_data, in_reg, out_ready,
    output in_ready, out_valid, out_data, out_reg
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register: main entry drives outputs, one-entry skid buffer
// keeps in_ready purely registered. Adds flush, PC-preserving bubbles, stall counter.
module pipe_stage_skid #(
  parameter int unsigned    DW     = 32,
  parameter int unsigned    NCH    = 6,
  parameter int unsigned    REG_W  = 5,
  parameter int unsigned    PC_CH  = 0,
  parameter logic [DW-1:0]  RST_PC = 32'h0000_3000,
  parameter int unsigned    CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_skid_if.slave  bus,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);
  localparam int unsigned PW = NCH * DW;

  logic             mv;
  logic             sv;
  logic [PW-1:0]    m_data;
  logic [PW-1:0]    s_data;
  logic [REG_W-1:0] m_reg;
  logic [REG_W-1:0] s_reg;
  logic             accept;
  logic             stalled;

  // Keep only the PC channel of a payload; everything else reads as zero.
  function automatic logic [PW-1:0] pc_only(input logic [PW-1:0] d);
    logic [PW-1:0] r;
    r = '0;
    r[PC_CH*DW +: DW] = d[PC_CH*DW +: DW];
    return r;
  endfunction

  function automatic logic [PW-1:0] reset_data();
    logic [PW-1:0] r;
    r = '0;
    r[PC_CH*DW +: DW] = RST_PC;
    return r;
  endfunction

  assign accept        = bus.in_valid & ~sv;
  assign stalled       = mv & ~bus.out_ready;

  assign bus.in_ready  = ~sv;
  assign bus.out_valid = mv;
  assign bus.out_data  = m_data;
  assign bus.out_reg   = m_reg;
  assign occupancy     = 2'(mv) + 2'(sv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mv     <= 1'b0;
      sv     <= 1'b0;
      m_data <= reset_data();
      s_data <= reset_data();
      m_reg  <= '0;
      s_reg  <= '0;
    end else if (flush) begin
      mv     <= 1'b0;
      sv     <= 1'b0;
      m_data <= pc_only(m_data);
      m_reg  <= '0;
    end else if (!mv || bus.out_ready) begin
      // sv implies in_ready=0, so a skid refill never coincides with an accept.
      if (sv) begin
        mv     <= 1'b1;
        m_data <= s_data;
        m_reg  <= s_reg;
        sv     <= 1'b0;
      end else if (accept) begin
        mv     <= 1'b1;
        m_data <= bus.in_data;
        m_reg  <= bus.in_reg;
      end else begin
        mv     <= 1'b0;
        m_data <= pc_only(m_data);
        m_reg  <= '0;
      end
    end else if (accept) begin
      sv     <= 1'b1;
      s_data <= bus.in_data;
      s_reg  <= bus.in_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries NCH data channels of DW bits plus one REG_W-bit destination-register field between two pipeline stages. A valid/ready handshake and a one-entry skid buffer replace the plain stall input, so upstream never sees a combinational path from downstream ready. Adds flush, PC-preserving bubbles and a saturating stall-cycle counter for performance measurement.

Parameters:
DW, 32, width of each data channel
NCH, 6, number of data channels packed in in_data/out_data (channel k = bits [k*DW +: DW])
REG_W, 5, width of destination-register field
PC_CH, 0, index of the channel holding the PC; this channel is preserved on bubbles and flush
RST_PC, 32'h0000_3000, reset value of channel PC_CH
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream beat present
in_ready  out  1  block can accept a beat this cycle
in_data  in  NCH*DW  upstream payload
in_reg  in  REG_W  upstream destination register
out_valid  out  1  main entry holds a valid beat
out_ready  in  1  downstream consumes the beat this cycle
out_data  out  NCH*DW  main-entry payload
out_reg  out  REG_W  main-entry destination register (0 when invalid)
flush  in  1  kill all held beats
occupancy  out  2  number of valid entries, 0..2
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- State: main entry M (mv, data, reg) drives outputs directly; skid entry S (sv, data, reg).
- Reset (async, immediate): mv=sv=0, all data and reg fields 0 except channel PC_CH of M and S = RST_PC; stall_cnt=0. Outputs: out_valid=0, in_ready=1, occupancy=0, out_reg=0, out_data channel PC_CH = RST_PC, others 0.
- in_ready = !sv, derived from registered state only. No combinational path from out_ready or flush.
- accept = in_valid & in_ready; drain = mv & out_ready.
- Priority per edge: reset > flush > normal update.
- Normal update:
  - If !mv or drain: M loads S if sv (then S loads the input if accept, else sv=0); otherwise M loads the input if accept.
  - If mv & !out_ready: M holds; if accept, S loads the input, sv=1.
  - Strict FIFO order; no beat dropped or duplicated; latency from accept to out_valid is 1 cycle when empty.
- Bubble: when drain occurs with nothing to refill M, mv=0, out_reg=0 and all non-PC channels become 0. Channel PC_CH keeps the PC of the drained beat (exception-PC support).
- Flush: at the next edge mv=sv=0, M non-PC channels and reg = 0, M PC channel keeps its current value. A beat offered in the flush cycle is dropped, even if in_ready=1. stall_cnt is unaffected.
- occupancy = mv + sv. The value 2 implies in_ready=0.
- Stall counter: clear has priority over increment. Otherwise it increments when out_valid & !out_ready and saturates at all-ones.
- Reset asserted mid-transfer discards both entries without waiting for a clock.

Test Plan:
- Reset then release, idle: out_valid=0, in_ready=1, occupancy=0, out_data[PC]=0x3000, stall_cnt=0.
- Stream 4 beats (PC 0x3004,0x3008,0x300C,0x3010), out_ready=1 always: each appears 1 cycle after accept, in order, in_ready stays 1.
- Hold out_ready=0 while sending PC 0x3004,0x3008,0x300C: first two accepted, occupancy=2, in_ready=0, third waits. Release out_ready: 0x3004,0x3008,0x300C emerge in order. stall_cnt equals the number of stalled cycles.
- occupancy=2, assert flush with in_valid=1 PC 0x4000: next cycle out_valid=0, occupancy=0, out_data[PC] unchanged (0x3004), out_reg=0. Beat 0x4000 is not delivered.
- Single beat PC 0x3020, reg 5 drained with no follow-up: out_valid=0, out_reg=0, non-PC channels 0, out_data[PC]=0x3020.
- Force out_ready=0 for 2^CNT_W+3 cycles: stall_cnt saturates at all-ones. stall_cnt_clr together with a stall gives 0. Async reset pulse between edges: outputs return to reset values immediately.
